// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready handshake and sign-extended immediate.
// Define DECODE_SCOREBOARD_EN to add the RAW/WAW register scoreboard that stalls issue until writeback.
module decode_stage #(
  parameter int INSTR_W = 32,
  parameter int REG_W   = 6,
  parameter int FC_W    = 3,
  parameter int DATA_W  = 32,
  parameter logic [FC_W-1:0] FC_REGWR = 3'b100,
  parameter logic [FC_W-1:0] FC_MEMWR = 3'b110
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_ri,
  output logic [REG_W-1:0]   out_rs,
  output logic [REG_W-1:0]   out_rd,
  output logic [REG_W-1:0]   out_rt,
  output logic               out_mode,
  output logic [FC_W-1:0]    out_fcode,
  output logic [DATA_W-1:0]  out_imm,
  output logic               out_regwrite,
  output logic               out_memwrite,
  input  logic               wb_valid,
  input  logic [REG_W-1:0]   wb_rd,
  output logic               hazard_stall
);

  localparam int IMM_W = INSTR_W - 2 - 2*REG_W - FC_W;

  logic              d_ri;
  logic [REG_W-1:0]  d_rs;
  logic [REG_W-1:0]  d_rd;
  logic [REG_W-1:0]  d_rt;
  logic              d_mode;
  logic [FC_W-1:0]   d_fcode;
  logic [IMM_W-1:0]  d_low;
  logic [DATA_W-1:0] d_imm;
  logic              d_regwrite;
  logic              d_memwrite;
  logic              hazard;
  logic              fire;

  assign d_ri    = in_instr[INSTR_W-1];
  assign d_rs    = in_instr[INSTR_W-2 -: REG_W];
  assign d_rd    = in_instr[INSTR_W-2-REG_W -: REG_W];
  assign d_mode  = in_instr[IMM_W+FC_W];
  assign d_fcode = in_instr[IMM_W +: FC_W];
  assign d_low   = in_instr[IMM_W-1:0];

  // R-type carries rt in the top of the low field; I-type carries the immediate there.
  assign d_rt  = d_ri ? '0 : d_low[IMM_W-1 -: REG_W];
  assign d_imm = d_ri ? {{(DATA_W-IMM_W){d_low[IMM_W-1]}}, d_low} : '0;

  assign d_regwrite = (d_fcode == FC_REGWR) && !d_mode;
  assign d_memwrite = (d_fcode == FC_MEMWR) && !d_mode && !d_ri;

`ifdef DECODE_SCOREBOARD_EN
  logic [(2**REG_W)-1:0] pending;

  assign hazard = pending[d_rs]
                | (!d_ri && pending[d_rt])
                | (d_regwrite && pending[d_rd]);

  // Set is written last so it wins over a same-index writeback clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (wb_valid)
        pending[wb_rd] <= 1'b0;
      if (fire && d_regwrite)
        pending[d_rd] <= 1'b1;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_rd};
  assign hazard    = 1'b0;
`endif

  assign in_ready     = (!out_valid || out_ready) && !hazard;
  assign hazard_stall = in_valid && hazard;
  assign fire         = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_ri       <= 1'b0;
      out_rs       <= '0;
      out_rd       <= '0;
      out_rt       <= '0;
      out_mode     <= 1'b0;
      out_fcode    <= '0;
      out_imm      <= '0;
      out_regwrite <= 1'b0;
      out_memwrite <= 1'b0;
    end else if (fire) begin
      out_valid    <= 1'b1;
      out_ri       <= d_ri;
      out_rs       <= d_rs;
      out_rd       <= d_rd;
      out_rt       <= d_rt;
      out_mode     <= d_mode;
      out_fcode    <= d_fcode;
      out_imm      <= d_imm;
      out_regwrite <= d_regwrite;
      out_memwrite <= d_memwrite;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field decode, handshake/backpressure, scoreboard hazards, async reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        out_ri;
  logic [5:0]  out_rs, out_rd, out_rt;
  logic        out_mode;
  logic [2:0]  out_fcode;
  logic [31:0] out_imm;
  logic        out_regwrite, out_memwrite;
  logic        wb_valid;
  logic [5:0]  wb_rd;
  logic        hazard_stall;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [31:0] I_A = 32'h0212_0600;  // R: rs1 rd2 rt3 fc100
  localparam logic [31:0] I_B = 32'h8A3A_7FFF;  // I: rs5 rd7 fc100 imm -1
  localparam logic [31:0] I_C = 32'h8A3B_0001;  // I: rs5 rd7 fc110 imm 1
  localparam logic [31:0] I_D = 32'h0213_0600;  // R store: rs1 rd2 rt3 fc110
  localparam logic [31:0] I_E = 32'h0420_0000;  // R: rs2 rd4 rt0 fc000

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ri(out_ri), .out_rs(out_rs), .out_rd(out_rd), .out_rt(out_rt),
    .out_mode(out_mode), .out_fcode(out_fcode), .out_imm(out_imm),
    .out_regwrite(out_regwrite), .out_memwrite(out_memwrite),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .hazard_stall(hazard_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_fields", {out_rs, out_rd, out_rt, out_fcode, out_ri, out_mode, out_regwrite, out_memwrite}, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // R-type decode
    in_instr = I_A; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("a_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("a_valid", {31'd0, out_valid}, 32'd1);
    chk("a_ri", {31'd0, out_ri}, 32'd0);
    chk("a_rs", {26'd0, out_rs}, 32'd1);
    chk("a_rd", {26'd0, out_rd}, 32'd2);
    chk("a_rt", {26'd0, out_rt}, 32'd3);
    chk("a_fcode", {29'd0, out_fcode}, 32'd4);
    chk("a_ctl", {30'd0, out_regwrite, out_memwrite}, 32'd2);
    chk("a_imm", out_imm, 32'd0);
    tick();
    chk("a_drain", {31'd0, out_valid}, 32'd0);
    wb_valid = 1'b1; wb_rd = 6'd2;
    tick();
    wb_valid = 1'b0;

    // I-type decode with sign extension, then I-type fc=110 back to back
    in_instr = I_B; in_valid = 1'b1;
    tick();
    chk("b_ri", {31'd0, out_ri}, 32'd1);
    chk("b_rs", {26'd0, out_rs}, 32'd5);
    chk("b_rd", {26'd0, out_rd}, 32'd7);
    chk("b_rt", {26'd0, out_rt}, 32'd0);
    chk("b_imm", out_imm, 32'hFFFF_FFFF);
    chk("b_ctl", {30'd0, out_regwrite, out_memwrite}, 32'd2);
    in_instr = I_C;
    #1 chk("c_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("c_fcode", {29'd0, out_fcode}, 32'd6);
    chk("c_ctl", {30'd0, out_regwrite, out_memwrite}, 32'd0);
    chk("c_imm", out_imm, 32'd1);
    wb_valid = 1'b1; wb_rd = 6'd7;
    tick();
    wb_valid = 1'b0;

    // Store: memwrite only, no pending bit left on rd=2
    in_instr = I_D; in_valid = 1'b1;
    tick();
    chk("d_ctl", {30'd0, out_regwrite, out_memwrite}, 32'd1);
    in_instr = I_E;
    #1 chk("d_no_pend_stall", {31'd0, hazard_stall}, 32'd0);
    chk("d_no_pend_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("e_rs", {26'd0, out_rs}, 32'd2);
    tick();

    // Backpressure: hold D for three cycles with C waiting
    out_ready = 1'b0; in_instr = I_D; in_valid = 1'b1;
    tick();
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    in_instr = I_C;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", {out_rt, out_fcode, out_ri, out_memwrite, 21'd0}, {6'd3, 3'd6, 1'b0, 1'b1, 21'd0});
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_next_c", {out_ri, out_imm[30:0]}, {1'b1, 31'd1});
    in_instr = I_E;
    tick();
    in_valid = 1'b0;
    chk("bp_next_e", {20'd0, out_ri, out_rs, out_rd}, {20'd0, 1'b0, 6'd2, 6'd4});
    tick();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    // RAW hazard on rd=2
    in_instr = I_A; in_valid = 1'b1;
    tick();
    in_instr = I_E;
`ifdef DECODE_SCOREBOARD_EN
    #1 chk("raw_stall0", {30'd0, hazard_stall, in_ready}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("raw_stall", {30'd0, hazard_stall, out_valid}, 32'd2);
    end
    wb_valid = 1'b1; wb_rd = 6'd2;
    #1 chk("raw_no_bypass", {31'd0, hazard_stall}, 32'd1);
    tick();
    wb_valid = 1'b0;
    #1 chk("raw_cleared", {29'd0, hazard_stall, in_ready, out_valid}, 32'd2);
    tick();
    in_valid = 1'b0;
    chk("raw_accept", {25'd0, out_valid, out_rs}, {25'd0, 1'b1, 6'd2});
`else
    #1 chk("raw_nosb_ready", {30'd0, hazard_stall, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("raw_nosb_accept", {25'd0, out_valid, out_rs}, {25'd0, 1'b1, 6'd2});
`endif
    tick();

    // Async reset with a held instruction and pending[2]
    in_instr = I_A; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk("rs_held", {31'd0, out_valid}, 32'd1);
    in_instr = I_E;
`ifdef DECODE_SCOREBOARD_EN
    #1 chk("rs_pre_stall", {31'd0, hazard_stall}, 32'd1);
`else
    #1 chk("rs_pre_stall", {31'd0, hazard_stall}, 32'd0);
`endif
    rst = 1'b1;
    #1;
    chk("rs_async_valid", {31'd0, out_valid}, 32'd0);
    chk("rs_async_fields", {26'd0, out_rs}, 32'd0);
    chk("rs_async_pend", {30'd0, hazard_stall, in_ready}, 32'd1);
    rst = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("rs_accept", {19'd0, out_valid, out_rs, out_rd}, {19'd0, 1'b1, 6'd2, 6'd4});

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the custom 32-bit R/I-type ISA. Splits each instruction into register indices, mode, function code and immediate, and generates RegWrite/MemWrite. Adds a valid/ready handshake on both sides, one pipeline register, immediate sign-extension, and an optional register scoreboard that stalls issue on RAW/WAW hazards until writeback. Sits between instruction fetch and the register-file/execute stage.

## Interface
- `INSTR_W`, 32: instruction width.
- `REG_W`, 6: register-index width; the scoreboard tracks 2**REG_W registers.
- `FC_W`, 3: function-code width.
- `DATA_W`, 32: width of sign-extended immediate output.
- `FC_REGWR`, 3'b100: F_Code that writes a register.
- `FC_MEMWR`, 3'b110: F_Code that writes memory.
- Derived: `IMM_W = INSTR_W-2-2*REG_W-FC_W` (15 at defaults).

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: fetch presents an instruction.
- `in_instr` in INSTR_W: instruction word.
- `in_ready` out 1: stage accepts this cycle.
- `out_valid` out 1: decoded instruction held.
- `out_ready` in 1: downstream consumes.
- `out_ri` out 1: 0 = R-type, 1 = I-type.
- `out_rs`, `out_rd`, `out_rt` out REG_W: register indices. `out_rt` is 0 for I-type.
- `out_mode` out 1: mode bit.
- `out_fcode` out FC_W: function code.
- `out_imm` out DATA_W: sign-extended immediate. 0 for R-type.
- `out_regwrite`, `out_memwrite` out 1: control.
- `wb_valid` in 1, `wb_rd` in REG_W: writeback retires pending register `wb_rd`.
- `hazard_stall` out 1: in_valid held off only by the scoreboard.

## Operation
- Field layout, MSB down: ri[1], rs[REG_W], rd[REG_W], mode[1], fcode[FC_W], low IMM_W bits. In R-type, rt is the top REG_W bits of the low field and the rest is ignored.
- `regwrite = (fcode==FC_REGWR) && !mode`, for both types.
- `memwrite = (fcode==FC_MEMWR) && !mode && !ri`. It is never asserted for I-type.
- Accept (fire) when `in_valid && in_ready`. On fire, the output register loads all decoded fields and `out_valid` is set.
- Consume when `out_valid && out_ready`. With no new fire, `out_valid` clears.
- `in_ready = (!out_valid || out_ready) && !hazard`. This allows back-to-back throughput of one instruction per cycle.
- Output fields hold stable while `out_valid && !out_ready`.
- Scoreboard (`pending`, 2**REG_W bits), when compiled in:
  - `hazard` = `pending[rs]`, OR `pending[rt]` if R-type, OR `pending[rd]` if `regwrite`.
  - The check uses registered `pending` only. There is no bypass of a same-cycle writeback, so a stalled instruction accepts the cycle after the clearing `wb_valid`.
  - On fire with `regwrite`, set `pending[rd]`. On `wb_valid`, clear `pending[wb_rd]`.
  - Set and clear of the same index in one cycle cannot occur, because the WAW check blocks it. If it is forced anyway, set wins.
  - `wb_valid` on a non-pending index is a no-op.
  - `hazard_stall = in_valid && hazard`.
- Reset: `out_valid`=0, all `out_*` fields=0, `pending`=0, `in_ready` then reflects an empty stage.

## Timing
- Latency: fire in cycle N gives `out_valid` and fields valid in N+1.
- The scoreboard bit is visible to the hazard check from N+1.
- `in_ready` and `hazard_stall` are combinational from `in_instr`, `pending`, `out_valid` and `out_ready`. There is no path from `in_valid` to `in_ready`.
- An asynchronous reset mid-operation discards the held instruction and all pending bits immediately.

## Configuration
- `DECODE_SCOREBOARD_EN` defined: the scoreboard is present as described.
- Undefined:
  - No `pending` storage.
  - `hazard`=0 and `hazard_stall`=0.
  - `wb_valid`/`wb_rd` are ignored.
  - `in_ready = !out_valid || out_ready`.

## Test plan
- Reset, then R-type `0x0212_0600` with out_ready=1. Next cycle: ri=0, rs=1, rd=2, rt=3, fcode=100, regwrite=1, memwrite=0, imm=0.
- I-type `0x8A3A_7FFF`. Expect rs=5, rd=7, rt=0, imm=`0xFFFF_FFFF`, regwrite=1, memwrite=0. Then I-type with fcode=110: memwrite=0.
- Store `0x0213_0600`. Expect memwrite=1, regwrite=0, and no pending bit set.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1. Expect in_ready=0 and fields stable. On release, one transfer per cycle with no drop or duplicate.
- RAW (scoreboard on): issue `0x0212_0600`, then `0x0420_0000` (rs=2). Expect hazard_stall=1 until wb_valid with wb_rd=2, and acceptance exactly one cycle after. Scoreboard off: accepted immediately.
- Assert rst while out_valid=1 and pending[2]=1. Expect out_valid=0 and pending=0 asynchronously. The next `0x0420_0000` is accepted without stall.
